// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing types, 640x480@60 defaults and helpers
package vga_pkg;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_H = '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48};
  localparam vga_timing_t VGA_640X480_V = '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33};

  function automatic int vga_total(input vga_timing_t t);
    return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// rtl/vga_axis_cnt.sv - one timing axis: wrap counter with enable, carry-out, sync/active decode
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter vga_timing_t T  = VGA_640X480_H,
  parameter int          CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_carry,
  output logic          o_sync,
  output logic          o_active
);

  localparam int TOTAL = vga_total(T);
  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END = CW'(int'(T.active));
  localparam logic [CW-1:0] SYNC_LO = CW'(int'(T.active) + int'(T.fp));
  localparam logic [CW-1:0] SYNC_HI = CW'(int'(T.active) + int'(T.fp) + int'(T.sync) - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    o_carry = i_en && (cnt_q == LAST);
    cnt_d   = cnt_q;
    if (i_en) begin
      cnt_d = o_carry ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt    = cnt_q;
  assign o_sync   = (cnt_q >= SYNC_LO) && (cnt_q <= SYNC_HI);
  assign o_active = (cnt_q < ACT_END);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing with registered syncs, coordinates and tiles
// Optional 16-bit frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE    = int'(VGA_640X480_H.active),
  parameter int   H_FP        = int'(VGA_640X480_H.fp),
  parameter int   H_SYNC      = int'(VGA_640X480_H.sync),
  parameter int   H_BP        = int'(VGA_640X480_H.bp),
  parameter int   V_ACTIVE    = int'(VGA_640X480_V.active),
  parameter int   V_FP        = int'(VGA_640X480_V.fp),
  parameter int   V_SYNC      = int'(VGA_640X480_V.sync),
  parameter int   V_BP        = int'(VGA_640X480_V.bp),
  parameter logic HS_POL      = 1'b0,
  parameter logic VS_POL      = 1'b0,
  parameter int   SCALE_SHIFT = 4,
  parameter int   CW          = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_pix_en,
  output logic                      o_hsync,
  output logic                      o_vsync,
  output logic                      o_active,
  output logic [CW-1:0]             o_pix_x,
  output logic [CW-1:0]             o_pix_y,
  output logic [CW-SCALE_SHIFT-1:0] o_tile_x,
  output logic [CW-SCALE_SHIFT-1:0] o_tile_y,
  output logic                      o_line_start,
  output logic                      o_frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]               o_frame_cnt
`endif
);

  localparam vga_timing_t H_T = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
  localparam vga_timing_t V_T = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};

  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_carry, v_carry, h_sync, v_sync, h_act, v_act;

  vga_axis_cnt #(.T(H_T), .CW(CW)) u_h_cnt (
    .clk(clk), .rst(rst), .i_en(i_pix_en),
    .o_cnt(h_cnt), .o_carry(h_carry), .o_sync(h_sync), .o_active(h_act)
  );

  // The vertical axis advances only on the horizontal wrap.
  vga_axis_cnt #(.T(V_T), .CW(CW)) u_v_cnt (
    .clk(clk), .rst(rst), .i_en(h_carry),
    .o_cnt(v_cnt), .o_carry(v_carry), .o_sync(v_sync), .o_active(v_act)
  );

  logic                      hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
  logic [CW-1:0]             pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [CW-SCALE_SHIFT-1:0] tile_x_q, tile_x_d, tile_y_q, tile_y_d;
  logic                      line_start_q, line_start_d, frame_start_q, frame_start_d;

  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    tile_x_d      = tile_x_q;
    tile_y_d      = tile_y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (i_pix_en) begin
      hsync_d       = h_sync ? HS_POL : ~HS_POL;
      vsync_d       = v_sync ? VS_POL : ~VS_POL;
      active_d      = h_act && v_act;
      pix_x_d       = active_d ? h_cnt : '0;
      pix_y_d       = active_d ? v_cnt : '0;
      tile_x_d      = pix_x_d[CW-1:SCALE_SHIFT];
      tile_y_d      = pix_y_d[CW-1:SCALE_SHIFT];
      line_start_d  = (h_cnt == '0);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      active_q      <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      tile_x_q      <= '0;
      tile_y_q      <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      tile_x_q      <= tile_x_d;
      tile_y_q      <= tile_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_active      = active_q;
  assign o_pix_x       = pix_x_q;
  assign o_pix_y       = pix_y_q;
  assign o_tile_x      = tile_x_q;
  assign o_tile_y      = tile_y_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (v_carry) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
`else
  logic unused_v_carry;
  assign unused_v_carry = v_carry;
`endif

endmodule
